// File: rtl/srl_stream_fifo_pkg.sv
// Shared defaults for the SRL-backed stream FIFO and its tap line.
package srl_stream_fifo_pkg;
    localparam int SRL_DEF_WIDTH = 32;
    localparam int SRL_DEF_DEPTH = 128;
endpackage

// File: rtl/srl_stream_fifo_tap_line.sv
// Addressable shift line: shift in at tap 0, combinational read at any tap.
// No reset on purpose so synthesis can map it onto SRL primitives.
module srl_tap_line
    import srl_stream_fifo_pkg::*;
#(
    parameter int WIDTH = SRL_DEF_WIDTH,
    parameter int DEPTH = SRL_DEF_DEPTH,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    input  logic [AW-1:0]    addr,
    output logic [WIDTH-1:0] q
);
    logic [DEPTH-1:0][WIDTH-1:0] sr;

    always_ff @(posedge clk) begin
        if (en) sr <= {sr[DEPTH-2:0], d};
    end

    assign q = sr[addr];
endmodule

// File: rtl/srl_stream_fifo.sv
// Stream FIFO: SRL storage line followed by a registered output stage.
// Capacity is DEPTH words in the line plus one in the output register.
module srl_stream_fifo
    import srl_stream_fifo_pkg::*;
#(
    parameter int WIDTH = SRL_DEF_WIDTH,
    parameter int DEPTH = SRL_DEF_DEPTH,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH + 2)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clr,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_valid,
    output logic             s_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [CW-1:0]    count
);
    logic [AW:0]      occ;
    logic [AW:0]      occ_m1;
    logic [WIDTH-1:0] tap_q;
    logic             wr;
    logic             ld;

    assign s_ready = (occ != (AW+1)'(DEPTH));
    assign wr      = s_valid && s_ready && !clr;
    assign ld      = (occ != '0) && (!m_valid || m_ready);
    // occ-1 always points at the oldest word; value is ignored when occ==0
    assign occ_m1  = occ - 1'b1;

    srl_tap_line #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_line (
        .clk  (clk),
        .en   (wr),
        .d    (s_data),
        .addr (occ_m1[AW-1:0]),
        .q    (tap_q)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            occ     <= '0;
            m_valid <= 1'b0;
            m_data  <= '0;
        end else if (clr) begin
            occ     <= '0;
            m_valid <= 1'b0;
        end else begin
            // a simultaneous write and load leave occupancy unchanged
            if (wr && !ld)      occ <= occ + 1'b1;
            else if (!wr && ld) occ <= occ - 1'b1;
            if (ld) begin
                m_data  <= tap_q;
                m_valid <= 1'b1;
            end else if (m_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

    assign count = CW'(occ) + CW'(m_valid);
endmodule

// File: tb/tb_srl_stream_fifo.sv
// Bench for srl_stream_fifo: vector table, corner sequences, random scoreboard.
module tb_srl_stream_fifo;
    localparam int WIDTH = 32;
    localparam int DEPTH = 128;
    localparam int CW    = $clog2(DEPTH + 2);

    logic             clk = 1'b0;
    logic             rstn;
    logic             clr;
    logic [WIDTH-1:0] s_data;
    logic             s_valid;
    logic             s_ready;
    logic [WIDTH-1:0] m_data;
    logic             m_valid;
    logic             m_ready;
    logic [CW-1:0]    count;

    int checks = 0;
    int errors = 0;

    srl_stream_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rstn(rstn), .clr(clr),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .count(count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        clr;
        logic        sv;
        logic [31:0] sd;
        logic        mr;
        logic        ev;
        logic [31:0] ed;
        logic [7:0]  ec;
        logic        er;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        #3 rstn = 1'b0;
        #1;
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_m_data", m_data, 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_s_ready", 32'(s_ready), 32'd1);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic push_n(input int n, input logic [31:0] base);
        m_ready = 1'b0;
        for (int i = 0; i < n; i++) begin
            s_valid = 1'b1;
            s_data  = base + 32'(i);
            step();
        end
        s_valid = 1'b0;
    endtask

    // reference model: a queue for stored words plus the output register
    logic [31:0] mq[$];
    logic [31:0] sb[$];
    logic        mv;
    logic [31:0] md;

    initial begin
        rstn = 1'b0; clr = 1'b0; s_data = '0; s_valid = 1'b0; m_ready = 1'b0;
        #12;
        do_reset();

        //             clr  sv  sd            mr   ev  ed            ec   er
        tbl[0] = '{1'b0, 1'b1, 32'hA5A5A5A5, 1'b1, 1'b0, 32'h0,        8'd1, 1'b1};
        tbl[1] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'hA5A5A5A5, 8'd1, 1'b1};
        tbl[2] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'hA5A5A5A5, 8'd0, 1'b1};
        tbl[3] = '{1'b0, 1'b1, 32'h11,       1'b0, 1'b0, 32'hA5A5A5A5, 8'd1, 1'b1};
        tbl[4] = '{1'b0, 1'b1, 32'h22,       1'b0, 1'b1, 32'h11,       8'd2, 1'b1};
        tbl[5] = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h11,       8'd2, 1'b1};
        tbl[6] = '{1'b1, 1'b1, 32'h33,       1'b1, 1'b0, 32'h11,       8'd0, 1'b1};
        tbl[7] = '{1'b0, 1'b1, 32'h44,       1'b0, 1'b0, 32'h11,       8'd1, 1'b1};
        tbl[8] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h44,       8'd1, 1'b1};
        tbl[9] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h44,       8'd0, 1'b1};
        for (int i = 0; i < 10; i++) begin
            clr = tbl[i].clr; s_valid = tbl[i].sv; s_data = tbl[i].sd; m_ready = tbl[i].mr;
            step();
            chk($sformatf("vec%0d_m_valid", i), 32'(m_valid), 32'(tbl[i].ev));
            chk($sformatf("vec%0d_m_data", i), m_data, tbl[i].ed);
            chk($sformatf("vec%0d_count", i), 32'(count), 32'(tbl[i].ec));
            chk($sformatf("vec%0d_s_ready", i), 32'(s_ready), 32'(tbl[i].er));
        end
        clr = 1'b0; s_valid = 1'b0; m_ready = 1'b0;

        // fill to full capacity, then drain in order
        push_n(DEPTH + 1, 32'd0);
        chk("full_count", 32'(count), 32'(DEPTH + 1));
        chk("full_s_ready", 32'(s_ready), 32'd0);
        s_valid = 1'b1; s_data = 32'd999;
        step();
        s_valid = 1'b0;
        chk("full_blocked_count", 32'(count), 32'(DEPTH + 1));
        m_ready = 1'b1;
        for (int i = 0; i <= DEPTH; i++) begin
            chk("drain_m_valid", 32'(m_valid), 32'd1);
            chk("drain_m_data", m_data, 32'(i));
            step();
        end
        chk("drain_m_valid_end", 32'(m_valid), 32'd0);
        chk("drain_count_end", 32'(count), 32'd0);

        // steady state streaming with occ=5 and the output register full
        begin
            logic [31:0] nxt_in, nxt_out;
            push_n(6, 32'd1000);
            chk("stream_count0", 32'(count), 32'd6);
            nxt_in = 32'd1006; nxt_out = 32'd1000;
            m_ready = 1'b1;
            for (int i = 0; i < 20; i++) begin
                s_valid = 1'b1; s_data = nxt_in;
                chk("stream_m_valid", 32'(m_valid), 32'd1);
                chk("stream_m_data", m_data, nxt_out);
                step();
                nxt_in++; nxt_out++;
                chk("stream_count", 32'(count), 32'd6);
            end
            s_valid = 1'b0;
            for (int i = 0; i < 8; i++) step();
            chk("stream_drained", 32'(count), 32'd0);
        end

        // flush overrides a simultaneous write
        push_n(40, 32'd2000);
        chk("clr_pre_count", 32'(count), 32'd40);
        clr = 1'b1; s_valid = 1'b1; s_data = 32'hDEAD; m_ready = 1'b1;
        step();
        clr = 1'b0; s_valid = 1'b0;
        chk("clr_count", 32'(count), 32'd0);
        chk("clr_m_valid", 32'(m_valid), 32'd0);
        chk("clr_s_ready", 32'(s_ready), 32'd1);
        s_valid = 1'b1; s_data = 32'h11;
        step();
        s_valid = 1'b0;
        step();
        chk("clr_next_valid", 32'(m_valid), 32'd1);
        chk("clr_next_data", m_data, 32'h11);
        step();

        // asynchronous reset mid-stream
        push_n(17, 32'd3000);
        chk("rst_mid_pre_count", 32'(count), 32'd17);
        do_reset();
        s_valid = 1'b1; s_data = 32'h5A; m_ready = 1'b1;
        step();
        s_valid = 1'b0;
        step();
        chk("rst_resume_valid", 32'(m_valid), 32'd1);
        chk("rst_resume_data", m_data, 32'h5A);

        // randomized traffic against the queue model
        m_ready = 1'b0;
        do_reset();
        mq.delete(); sb.delete(); mv = 1'b0; md = '0;
        begin
            int accepted = 0;
            int cyc = 0;
            logic wr, ld;
            while ((accepted < 10000 || sb.size() != 0) && cyc < 60000) begin
                s_valid = (accepted < 10000) && ($urandom_range(99) < 30);
                s_data  = $urandom;
                m_ready = ($urandom_range(99) < 70);
                #1;
                chk("rnd_s_ready", 32'(s_ready), 32'(mq.size() != DEPTH));
                wr = s_valid && (mq.size() != DEPTH);
                ld = (mq.size() != 0) && (!mv || m_ready);
                if (m_valid && m_ready) begin
                    if (sb.size() == 0) chk("rnd_spurious_out", 32'd1, 32'd0);
                    else chk("rnd_order", m_data, sb.pop_front());
                end
                if (wr) begin
                    sb.push_back(s_data);
                    accepted++;
                end
                step();
                if (ld) begin
                    md = mq.pop_front();
                    mv = 1'b1;
                end else if (mv && m_ready) begin
                    mv = 1'b0;
                end
                if (wr) mq.push_back(s_data);
                chk("rnd_m_valid", 32'(m_valid), 32'(mv));
                chk("rnd_m_data", m_data, md);
                chk("rnd_count", 32'(count), 32'(mq.size()) + 32'(mv));
                cyc++;
            end
            if (cyc >= 60000) chk("rnd_timeout", 32'(cyc), 32'd0);
        end
        s_valid = 1'b0; m_ready = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/srl_stream_fifo.md
SRL_STREAM_FIFO -- requirements
Module: srl_stream_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 128, storage-line capacity in words; power of two, 4..1024.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port rstn, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port clr, input, 1, synchronous flush.
REQ-006 SHALL have port s_data, input, WIDTH, write-side word.
REQ-007 SHALL have port s_valid, input, 1, write-side word present.
REQ-008 SHALL have port s_ready, output, 1, write side may accept.
REQ-009 SHALL have port m_data, output, WIDTH, registered read-side word.
REQ-010 SHALL have port m_valid, output, 1, m_data holds a valid word.
REQ-011 SHALL have port m_ready, input, 1, read-side consumer takes m_data.
REQ-012 SHALL have port count, output, $clog2(DEPTH+2), words held (storage occupancy plus output register).

Function
REQ-013 SHALL accept a write on an edge where s_valid && s_ready && !clr; the word shifts in at tap 0 and all stored words move up one tap.
REQ-014 SHALL drive s_ready = (occ != DEPTH), where occ is the internal storage occupancy, 0..DEPTH.
REQ-015 SHALL read storage combinationally at tap address occ-1, which is always the oldest stored word.
REQ-016 SHALL load the output register on an edge where occ != 0 and (!m_valid || m_ready); occ decrements and m_valid becomes 1.
REQ-017 SHALL clear m_valid on an edge where m_valid && m_ready and no load occurs.
REQ-018 SHALL hold occ when a write and a load occur on the same edge; the tap read uses pre-shift contents.
REQ-019 SHALL NOT bypass storage: a word accepted on edge E into an empty FIFO appears with m_valid=1 after edge E+1.
REQ-020 SHALL hold m_data and m_valid stable while m_valid && !m_ready.
REQ-021 SHALL give total capacity DEPTH+1 words; count = occ + m_valid.
REQ-022 SHALL, when clr=1, set occ=0 and m_valid=0 on that edge, overriding a simultaneous write or load; storage contents are left unchanged.
REQ-023 SHALL preserve order: words leave exactly in acceptance order, with no loss or duplication.

Reset
REQ-024 SHALL force occ=0, m_valid=0, m_data=0 asynchronously while rstn=0; s_ready=1 and count=0 follow.
REQ-025 SHALL abort in-flight traffic on reset mid-operation; the first word accepted after release is the first word delivered.
REQ-026 SHALL NOT reset storage-line contents.

Structure
REQ-027 SHALL keep WIDTH and DEPTH as module parameters; no shared package is required, and address width is derived as $clog2(DEPTH).
REQ-028 SHALL instantiate one sub-module, srl_tap_line: a WIDTH x DEPTH addressable shift line with shift-enable, no reset, and combinational tap read, mappable to SRL primitives.
REQ-029 SHALL contain the occ counter, output register and handshake logic in the top level only.

Verification
REQ-030 SHALL cover: after reset, write 0xA5A5A5A5 on edge E with m_ready=1 -> m_valid=1 and m_data=0xA5A5A5A5 after E+1; count=1, then 0 after the read edge.
REQ-031 SHALL cover: m_ready=0, write 129 words 0..128 (DEPTH=128) -> s_ready=0 after the 129th accept, count=129; then m_ready=1 -> outputs 0..128 in order, one per cycle.
REQ-032 SHALL cover: occ=5, m_valid=1, continuous s_valid and m_ready=1 -> count stays 6 and the output sequence is uninterrupted.
REQ-033 SHALL cover: count=40, then clr=1 together with s_valid=1 -> count=0, m_valid=0, s_ready=1; the next write 0x11 is the next word out.
REQ-034 SHALL cover: rstn pulsed low asynchronously mid-stream at count=17 -> m_valid=0, m_data=0, count=0 immediately; normal traffic resumes after release.
REQ-035 SHALL cover: random s_valid/m_ready at 30%/70% for 10000 words -> a scoreboard detects no mismatch, and no accept occurs while s_ready=0.
